alu_arbiter_seq: RTL and testbench

Sequencer and two-way round-robin arbiter for the shared 16-bit Full_ALU. It accepts operation requests from two requesters (0: instruction execute, 1: address/branch calculation) over valid/ready handshakes and drives the Full_ALU operand latches, ALUout latch, ALUop and Func. It captures Result and flags into a registered response with its own valid/ready handshake. It sits between the control unit and Full_ALU; it is the only block permitted to drive Full_ALU inputs.

---
 rtl/alu_arbiter_seq.sv | 176 +++++++++++++++++
 tb/tb_alu_arbiter_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_seq.sv
// Two-way round-robin arbiter and sequencer for the shared 16-bit Full_ALU.
// One accepted request walks IDLE -> LOAD -> EXEC -> CAPT -> RESP, then back to IDLE.
module alu_arbiter_seq (
  input  logic        clk,
  input  logic        reset,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [1:0]  req0_aluop,
  input  logic [3:0]  req0_func,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [1:0]  req1_aluop,
  input  logic [3:0]  req1_func,

  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic        alu_A_write,
  output logic        alu_B_write,
  output logic        alu_ALUout_write,
  output logic [1:0]  alu_ALUop,
  output logic [3:0]  alu_Func,
  input  logic [15:0] alu_Result,
  input  logic        alu_isNegative,
  input  logic        alu_overflow,
  input  logic        alu_isZero,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic        rsp_isNegative,
  output logic        rsp_overflow,
  output logic        rsp_isZero,

  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_EXEC = 3'd2;
  localparam logic [2:0] ST_CAPT = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  logic [2:0]  r_state;
  logic        r_last_grant;
  logic [15:0] r_op_a;
  logic [15:0] r_op_b;
  logic [1:0]  r_op_aluop;
  logic [3:0]  r_op_func;
  logic        r_op_id;

  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [15:0] r_rsp_result;
  logic        r_rsp_neg;
  logic        r_rsp_ovf;
  logic        r_rsp_zero;

  logic [2:0]  w_next_state;
  logic        w_idle;
  logic        w_any_valid;
  logic        w_grant;
  logic        w_accept;
  logic        w_drive;
  logic [15:0] w_sel_a;
  logic [15:0] w_sel_b;
  logic [1:0]  w_sel_aluop;
  logic [3:0]  w_sel_func;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on anything but state, reset and the valids.
  assign w_idle      = (r_state == ST_IDLE) && !reset;
  assign w_any_valid = req0_valid || req1_valid;

  // On a tie the requester not served last time wins.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_accept   = w_idle && w_any_valid;
  assign req0_ready = w_idle && req0_valid && !w_grant;
  assign req1_ready = w_idle && req1_valid && w_grant;

  assign w_sel_a     = w_grant ? req1_a     : req0_a;
  assign w_sel_b     = w_grant ? req1_b     : req0_b;
  assign w_sel_aluop = w_grant ? req1_aluop : req0_aluop;
  assign w_sel_func  = w_grant ? req1_func  : req0_func;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_LOAD;
      ST_LOAD: w_next_state = ST_EXEC;
      ST_EXEC: w_next_state = ST_CAPT;
      ST_CAPT: w_next_state = ST_RESP;
      ST_RESP: if (rsp_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_aluop   <= '0;
      r_op_func    <= '0;
      r_op_id      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_op_a       <= w_sel_a;
        r_op_b       <= w_sel_b;
        r_op_aluop   <= w_sel_aluop;
        r_op_func    <= w_sel_func;
        r_op_id      <= w_grant;
        r_last_grant <= w_grant;
      end
    end
  end

  // Result and flags arrive from the ALUout latch during CAPT and are held until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_neg    <= 1'b0;
      r_rsp_ovf    <= 1'b0;
      r_rsp_zero   <= 1'b0;
    end else if (r_state == ST_CAPT) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= r_op_id;
      r_rsp_result <= alu_Result;
      r_rsp_neg    <= alu_isNegative;
      r_rsp_ovf    <= alu_overflow;
      r_rsp_zero   <= alu_isZero;
    end else if ((r_state == ST_RESP) && rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign w_drive = (r_state == ST_LOAD) || (r_state == ST_EXEC) || (r_state == ST_CAPT);

  assign alu_A            = w_drive ? r_op_a     : 16'h0000;
  assign alu_B            = w_drive ? r_op_b     : 16'h0000;
  assign alu_ALUop        = w_drive ? r_op_aluop : 2'b00;
  assign alu_Func         = w_drive ? r_op_func  : 4'h0;
  assign alu_A_write      = (r_state == ST_LOAD);
  assign alu_B_write      = (r_state == ST_LOAD);
  assign alu_ALUout_write = (r_state == ST_EXEC);

  assign rsp_valid      = r_rsp_valid;
  assign rsp_id         = r_rsp_id;
  assign rsp_result     = r_rsp_result;
  assign rsp_isNegative = r_rsp_neg;
  assign rsp_overflow   = r_rsp_ovf;
  assign rsp_isZero     = r_rsp_zero;

  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Bench for alu_arbiter_seq: Full_ALU model, directed test-plan cases, then random traffic
// checked every cycle against a transaction-level reference with an expected queue.
module tb_alu_arbiter_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rsp_rdy;
  logic        p_v  [2];
  logic [15:0] p_a  [2];
  logic [15:0] p_b  [2];
  logic [1:0]  p_op [2];
  logic [3:0]  p_fn [2];

  logic        req0_ready, req1_ready;
  logic [15:0] alu_A, alu_B;
  logic        alu_A_write, alu_B_write, alu_ALUout_write;
  logic [1:0]  alu_ALUop;
  logic [3:0]  alu_Func;
  logic [15:0] alu_Result;
  logic        alu_isNegative, alu_overflow, alu_isZero;
  logic        rsp_valid, rsp_id, rsp_isNegative, rsp_overflow, rsp_isZero;
  logic [15:0] rsp_result;
  logic        busy;
  logic [2:0]  dbg_state;

  alu_arbiter_seq dut (
    .clk(clk), .reset(reset),
    .req0_valid(p_v[0]), .req0_ready(req0_ready), .req0_a(p_a[0]), .req0_b(p_b[0]),
    .req0_aluop(p_op[0]), .req0_func(p_fn[0]),
    .req1_valid(p_v[1]), .req1_ready(req1_ready), .req1_a(p_a[1]), .req1_b(p_b[1]),
    .req1_aluop(p_op[1]), .req1_func(p_fn[1]),
    .alu_A(alu_A), .alu_B(alu_B), .alu_A_write(alu_A_write), .alu_B_write(alu_B_write),
    .alu_ALUout_write(alu_ALUout_write), .alu_ALUop(alu_ALUop), .alu_Func(alu_Func),
    .alu_Result(alu_Result), .alu_isNegative(alu_isNegative), .alu_overflow(alu_overflow),
    .alu_isZero(alu_isZero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_rdy), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_isNegative(rsp_isNegative), .rsp_overflow(rsp_overflow), .rsp_isZero(rsp_isZero),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Full_ALU behaviour: returns {isNegative, overflow, isZero, result}.
  function automatic logic [18:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] op, input logic [3:0] fn);
    logic [15:0] r;
    logic        v;
    logic [3:0]  k;
    r = 16'h0;
    v = 1'b0;
    k = (op == 2'd0) ? 4'd2 : (op == 2'd1) ? 4'd3 : (op == 2'd3) ? 4'd1 : fn;
    case (k)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'd3: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'd4: r = ~(a | b);
      4'd5: r = ~(a & b);
      4'd6: r = a ^ b;
      4'd7: r = ~(a ^ b);
      default: r = a;
    endcase
    return {r[15], v, (r == 16'h0), r};
  endfunction

  logic [15:0] m_alu_a = 16'h0;
  logic [15:0] m_alu_b = 16'h0;
  logic [18:0] m_alu_o = 19'h0;
  always @(posedge clk) begin
    if (alu_A_write) m_alu_a <= alu_A;
    if (alu_B_write) m_alu_b <= alu_B;
    if (alu_ALUout_write) m_alu_o <= alu_f(m_alu_a, m_alu_b, alu_ALUop, alu_Func);
  end
  assign alu_Result     = m_alu_o[15:0];
  assign alu_isZero     = m_alu_o[16];
  assign alu_overflow   = m_alu_o[17];
  assign alu_isNegative = m_alu_o[18];

  // Reference: one op in flight, counted in cycles since its accept edge.
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          m_busy   = 1'b0;
  int          m_age    = 0;
  bit          m_last   = 1'b1;
  logic [15:0] c_a, c_b;
  logic [1:0]  c_op;
  logic [3:0]  c_fn;
  logic [19:0] exp_q [$];
  logic [19:0] gold_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int winner(input logic v0, input logic v1, input bit last);
    if (v0 && v1) return last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  // Inputs are set at the falling edge; outputs are checked 1 ns later.
  task automatic step();
    int          w;
    int          acc;
    bit          drv;
    bit          rv;
    logic [19:0] got_rsp;
    acc = -1;
    #1;
    w   = winner(p_v[0], p_v[1], m_last);
    drv = m_busy && (m_age >= 1) && (m_age <= 3);
    rv  = m_busy && (m_age >= 4);
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("ready0", 32'(req0_ready), 32'(!reset && !m_busy && (w == 0)));
    check_eq("ready1", 32'(req1_ready), 32'(!reset && !m_busy && (w == 1)));
    check_eq("alu_A", 32'(alu_A), drv ? 32'(c_a) : 32'd0);
    check_eq("alu_B", 32'(alu_B), drv ? 32'(c_b) : 32'd0);
    check_eq("alu_op_func", 32'({alu_ALUop, alu_Func}), drv ? 32'({c_op, c_fn}) : 32'd0);
    check_eq("ab_write", 32'({alu_A_write, alu_B_write}), (m_busy && m_age == 1) ? 32'd3 : 32'd0);
    check_eq("out_write", 32'(alu_ALUout_write), 32'(m_busy && m_age == 2));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(rv));
    got_rsp = {rsp_id, rsp_isNegative, rsp_overflow, rsp_isZero, rsp_result};
    if (rv) begin
      if (exp_q.size() == 0) check_eq("rsp_no_expect", 32'd1, 32'd0);
      else check_eq("rsp_fields", 32'(got_rsp), 32'(exp_q[0]));
    end
    @(posedge clk);
    if (reset) begin
      m_busy = 1'b0;
      m_last = 1'b1;
      exp_q.delete();
    end else if (!m_busy) begin
      if (w >= 0) begin
        acc  = w;
        c_a  = p_a[w];
        c_b  = p_b[w];
        c_op = p_op[w];
        c_fn = p_fn[w];
        exp_q.push_back({w[0], alu_f(c_a, c_b, c_op, c_fn)});
        m_last = w[0];
        m_busy = 1'b1;
        m_age  = 1;
      end
    end else if (m_age >= 4) begin
      if (rsp_rdy) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (gold_q.size() > 0) check_eq("gold_rsp", 32'(got_rsp), 32'(gold_q.pop_front()));
        m_busy = 1'b0;
      end
    end else begin
      m_age++;
    end
    @(negedge clk);
    if (acc >= 0) p_v[acc] = 1'b0;
  endtask

  task automatic put(input int i, input logic [15:0] a, input logic [15:0] b,
                     input logic [1:0] op, input logic [3:0] fn);
    p_v[i] = 1'b1; p_a[i] = a; p_b[i] = b; p_op[i] = op; p_fn[i] = fn;
  endtask

  task automatic run_quiet(input int max);
    int n;
    n = 0;
    while ((p_v[0] || p_v[1] || m_busy) && n < max) begin
      step();
      n++;
    end
    check_eq("drain", 32'(p_v[0] || p_v[1] || m_busy), 32'd0);
  endtask

  task automatic wait_age(input int age, input int max);
    int n;
    n = 0;
    while (!(m_busy && m_age >= age) && n < max) begin
      step();
      n++;
    end
    check_eq("wait_age", 32'(m_busy && m_age >= age), 32'd1);
  endtask

  function automatic logic [15:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h7FFF;
      3: return 16'hFFFF;
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    reset = 1'b1; rsp_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      p_v[i] = 1'b0; p_a[i] = '0; p_b[i] = '0; p_op[i] = '0; p_fn[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    put(0, 16'd1, 16'd1, 2'd0, 4'd0);
    repeat (2) step();
    p_v[0] = 1'b0;
    reset = 1'b0; rsp_rdy = 1'b1;
    step();

    // Tie from reset goes to requester 0, then 1; re-presented tie goes to 0 again.
    put(0, 16'd10, 16'd2, 2'd1, 4'd0);
    put(1, 16'h4000, 16'h4000, 2'd0, 4'd0);
    gold_q.push_back({1'b0, 3'b000, 16'd8});
    gold_q.push_back({1'b1, 3'b110, 16'h8000});
    run_quiet(40);
    put(0, 16'd10, 16'd2, 2'd1, 4'd0);
    put(1, 16'h4000, 16'h4000, 2'd0, 4'd0);
    gold_q.push_back({1'b0, 3'b000, 16'd8});
    gold_q.push_back({1'b1, 3'b110, 16'h8000});
    run_quiet(40);

    put(0, 16'd2, 16'd5, 2'd0, 4'd0);
    gold_q.push_back({1'b0, 3'b000, 16'd7});
    run_quiet(20);
    put(0, 16'd4, 16'd4, 2'd1, 4'd0);
    gold_q.push_back({1'b0, 3'b001, 16'd0});
    run_quiet(20);
    put(0, 16'd0, 16'd8, 2'd1, 4'd0);
    gold_q.push_back({1'b0, 3'b100, 16'hFFF8});
    run_quiet(20);
    put(1, 16'h5500, 16'h957F, 2'd2, 4'd6);
    gold_q.push_back({1'b1, 3'b100, 16'hC07F});
    run_quiet(20);

    // Response back-pressure with another request waiting.
    rsp_rdy = 1'b0;
    put(0, 16'd1, 16'd1, 2'd0, 4'd0);
    gold_q.push_back({1'b0, 3'b000, 16'd2});
    wait_age(4, 20);
    put(0, 16'd3, 16'd4, 2'd0, 4'd0);
    gold_q.push_back({1'b0, 3'b000, 16'd7});
    repeat (5) step();
    rsp_rdy = 1'b1;
    run_quiet(30);

    // Reset during EXEC aborts the op; a fresh one completes afterwards.
    put(0, 16'd9, 16'd9, 2'd0, 4'd0);
    wait_age(2, 20);
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (4) step();
    put(0, 16'd6, 16'd4, 2'd0, 4'd0);
    gold_q.push_back({1'b0, 3'b000, 16'd10});
    run_quiet(20);
    check_eq("gold_drained", 32'(gold_q.size()), 32'd0);

    // Random traffic with withdrawals, back-pressure and occasional reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_v[i]) begin
          if ($urandom_range(0, 3) == 0)
            put(i, rnd_val(), rnd_val(), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end else if ($urandom_range(0, 31) == 0) begin
          p_v[i] = 1'b0;
        end
      end
      rsp_rdy = ($urandom_range(0, 2) != 0);
      reset   = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; rsp_rdy = 1'b1;
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    run_quiet(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
